mac_stream_unit: RTL and testbench
==================================

# mac_stream_unit

Parametrised, pipelined multiply-accumulate processing element for the matrix/vector datapath. It consumes a stream of operand pairs over a valid/ready handshake and accumulates their products into one dot-product result per vector, delimited by `in_last`. It optionally pre-loads the accumulator with an incoming partial sum (`prev`) for chained or retro accumulation. Results leave on a valid/ready output port together with a term count and an overflow flag. Instances sit one per processor lane between the operand scheduler and the result collector.

## Interface
- `DATA_W`, default 8: unsigned operand width of A and B.
- `ACC_W`, default 24: accumulator and result width; must satisfy ACC_W ≥ 2·DATA_W.
- `CNT_W`, default 8: width of the per-vector term counter.
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: operand pair is valid.
- `in_ready`, out, 1: unit accepts the pair this cycle.
- `in_a`, in, DATA_W: operand A, unsigned.
- `in_b`, in, DATA_W: operand B, unsigned.
- `in_last`, in, 1: this pair is the final term of the vector.
- `cfg_retro`, in, 1: sampled on the first term of each vector; if 1, `prev` seeds the accumulator.
- `prev`, in, ACC_W: seed value, sampled together with `cfg_retro`.
- `out_valid`, out, 1: result is valid.
- `out_ready`, in, 1: downstream consumes the result.
- `out_data`, out, ACC_W: dot-product result.
- `out_count`, out, CNT_W: number of terms in the vector, saturating at 2^CNT_W−1.
- `out_ovf`, out, 1: accumulator overflow occurred in this vector.

## Operation
- Input handshake: a transfer occurs when `in_valid` and `in_ready` are both high.
- Stall condition: `stall = out_valid & ~out_ready`. `in_ready = ~stall`, combinational.
- Stage 1, on each accepted pair:
  - register `product = in_a*in_b` (2·DATA_W bits, zero-extended to ACC_W);
  - register `s1_last`;
  - register `s1_first`, which is high for the first pair after reset or after a pair with `in_last`;
  - register the seed, which is `prev` if `cfg_retro` else 0.
- Stage 1 holds its contents while `stall` is high. `s1_valid` clears when no pair is accepted and there is no stall.
- Stage 2: when `s1_valid & ~stall`:
  - `acc = (s1_first ? seed : acc) + product`;
  - `cnt = s1_first ? 1 : cnt+1`, saturating;
  - `ovf = (s1_first ? 0 : ovf) | carry-out`.
- When `s1_last` is also high in that update, `out_valid` is set next edge. `out_data`/`out_count`/`out_ovf` are the acc/cnt/ovf registers.
- `out_valid` clears on `out_valid & out_ready`, unless a new last term completes in the same cycle, in which case it stays high with the new result.
- A single-term vector (first and last on the same pair) is valid: result = seed + product, count 1.
- `in_last` with `in_valid` low is ignored.
- Reset (asserted at any time, mid-vector included): all outputs 0, `in_ready` = 1 after deassert, pipeline emptied, next accepted pair is treated as a first term.

## Timing
- Latency: pair with `in_last` accepted at edge t → product registered at t → result registered and `out_valid` high after edge t+1. That is 2 cycles from acceptance to visible result.
- Throughput: one pair per cycle with no bubbles between back-to-back vectors while `out_ready` = 1.
- Backpressure: with `out_valid` = 1 and `out_ready` = 0:
  - `in_ready` = 0 in the same cycle;
  - `out_data`, `out_count`, `out_ovf` and stage 1 are frozen;
  - at most one pair is held in stage 1.
- Reset values: `in_ready` 1 (0 while `rst` low is acceptable), `out_valid` 0, `out_data` 0, `out_count` 0, `out_ovf` 0.

## Configuration
- `MAC_SATURATE_EN` defined: on carry-out, `acc` clamps to 2^ACC_W−1 and stays clamped for the rest of the vector. `out_ovf` is still set.
- `MAC_SATURATE_EN` undefined: the sum wraps modulo 2^ACC_W and `out_ovf` is set.

## Test plan
- Vector (3,4),(5,6),(7,8 last), `cfg_retro`=0, `out_ready`=1 → 2 cycles after the last pair: `out_data`=98, `out_count`=3, `out_ovf`=0.
- Single term (10,10 last) with `cfg_retro`=1, `prev`=1000 → `out_data`=1100, `out_count`=1.
- Back-to-back vectors (2,2 last),(3,3 last) on consecutive cycles → `out_valid` high for 2 consecutive cycles with results 4 then 9.
- Hold `out_ready`=0 with a result pending, drive 5 more pairs → `in_ready`=0 and `out_data` unchanged; release → results are correct, with no lost or duplicated terms.
- ACC_W=16, pairs (255,255),(255,255 last) → `out_ovf`=1; `out_data`=64514 without `MAC_SATURATE_EN`, 65535 with it.
- Assert `rst` after 2 of 4 pairs, then send (1,1 last) → `out_data`=1, `out_count`=1; outputs are 0 during reset.

Source files
------------

// File: rtl/mac_stream_unit_if.sv
// -----------------------------------------------------------------------------
// mac_stream_unit_if
//
// Purpose: bundles the operand stream, seed and result port of one MAC lane.
//
// Signals:
//   in_valid / in_ready   operand pair handshake
//   in_a, in_b            unsigned operands (DATA_W)
//   in_last               final term of the current vector
//   cfg_retro, prev       seed select and seed value, used on a first term
//   out_valid / out_ready result handshake
//   out_data              dot-product result (ACC_W)
//   out_count             terms in the vector, saturating (CNT_W)
//   out_ovf               accumulator overflow seen in the vector
//
// Modports:
//   master  operand scheduler / result collector side
//   slave   mac_stream_unit side
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface mac_stream_unit_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_last;
  logic              cfg_retro;
  logic [ACC_W-1:0]  prev;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, cfg_retro, prev, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, cfg_retro, prev, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );
endinterface

// File: rtl/mac_stream_unit.sv
// -----------------------------------------------------------------------------
// mac_stream_unit
//
// Purpose: two-stage pipelined multiply-accumulate lane. Stage 1 registers
// the product of each accepted operand pair together with its first/last
// markers and seed; stage 2 folds the product into the accumulator and
// raises out_valid when the last term of a vector has been added.
//
// Ports:
//   clk     clock, rising edge
//   rst     asynchronous, active-low reset
//   bus_if  mac_stream_unit_if.slave (operand stream in, result stream out)
//
// Parameters:
//   DATA_W  operand width (unsigned)
//   ACC_W   accumulator / result width, ACC_W >= 2*DATA_W
//   CNT_W   term counter width, counter saturates at all-ones
//
// Build option:
//   MAC_SATURATE_EN  when defined, an overflowing sum clamps the accumulator
//                    to all-ones; otherwise the sum wraps. out_ovf is set on
//                    overflow in both builds.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mac_stream_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mac_stream_unit_if.slave      bus_if
);

  localparam int PROD_W = 2 * DATA_W;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic stall;
  logic accept;

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic              s1_valid_q, s1_valid_d;
  logic [ACC_W-1:0]  s1_prod_q,  s1_prod_d;
  logic              s1_last_q,  s1_last_d;
  logic              s1_first_q, s1_first_d;
  logic [ACC_W-1:0]  s1_seed_q,  s1_seed_d;
  // High when the next accepted pair opens a new vector.
  logic              first_pend_q, first_pend_d;

  // ---------------------------------------------------------------------------
  // Stage 2 registers (accumulator doubles as the result register)
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic [PROD_W-1:0] prod_w;
  logic              update;
  logic [ACC_W-1:0]  base_w;
  logic [ACC_W:0]    sum_w;
  logic              carry_w;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  // Operands are widened before multiplying so the full product is kept.
  assign prod_w = {{DATA_W{1'b0}}, bus_if.in_a} * {{DATA_W{1'b0}}, bus_if.in_b};

  // A result that is held but not taken freezes the whole pipeline.
  assign stall  = out_valid_q & ~bus_if.out_ready;
  assign accept = bus_if.in_valid & ~stall;
  assign update = s1_valid_q & ~stall;

  // A first term restarts from its seed instead of the running sum.
  assign base_w  = s1_first_q ? s1_seed_q : acc_q;
  assign sum_w   = {1'b0, base_w} + {1'b0, s1_prod_q};
  assign carry_w = sum_w[ACC_W];

  // ---------------------------------------------------------------------------
  // Stage 1 next state
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_prod_d    = s1_prod_q;
    s1_last_d    = s1_last_q;
    s1_first_d   = s1_first_q;
    s1_seed_d    = s1_seed_q;
    first_pend_d = first_pend_q;

    if (!stall) begin
      // Without a new pair the stage drains; with one it reloads.
      s1_valid_d = accept;
      if (accept) begin
        s1_prod_d    = ACC_W'(prod_w);
        s1_last_d    = bus_if.in_last;
        s1_first_d   = first_pend_q;
        s1_seed_d    = bus_if.cfg_retro ? bus_if.prev : '0;
        // in_last is only meaningful on an accepted pair.
        first_pend_d = bus_if.in_last;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 next state
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    if (update) begin
`ifdef MAC_SATURATE_EN
      // Once clamped at all-ones any nonzero product carries again, so the
      // accumulator stays clamped for the remainder of the vector.
      acc_d = carry_w ? ACC_MAX : sum_w[ACC_W-1:0];
`else
      acc_d = sum_w[ACC_W-1:0];
`endif
      if (s1_first_q) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      ovf_d = (s1_first_q ? 1'b0 : ovf_q) | carry_w;
    end

    // A completing vector wins over the consume, so a back-to-back result
    // keeps out_valid high for another cycle.
    if (update && s1_last_q) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus_if.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s1_prod_q    <= '0;
      s1_last_q    <= 1'b0;
      s1_first_q   <= 1'b0;
      s1_seed_q    <= '0;
      first_pend_q <= 1'b1;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_prod_q    <= s1_prod_d;
      s1_last_q    <= s1_last_d;
      s1_first_q   <= s1_first_d;
      s1_seed_q    <= s1_seed_d;
      first_pend_q <= first_pend_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      out_valid_q  <= out_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus_if.in_ready  = ~stall;
  assign bus_if.out_valid = out_valid_q;
  assign bus_if.out_data  = acc_q;
  assign bus_if.out_count = cnt_q;
  assign bus_if.out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_stream_unit.sv
`timescale 1ns/1ps

module tb_mac_stream_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus drives two lanes: the default 24-bit lane and a 16-bit
  // lane with a 2-bit counter used for overflow and count saturation.
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        in_last = 1'b0;
  logic        cfg_retro = 1'b0;
  logic [23:0] prev = '0;
  logic        out_ready = 1'b1;

  mac_stream_unit_if #(.DATA_W(8), .ACC_W(24), .CNT_W(8)) bus24 ();
  mac_stream_unit_if #(.DATA_W(8), .ACC_W(16), .CNT_W(2)) bus16 ();

  assign bus24.in_valid  = in_valid;
  assign bus24.in_a      = in_a;
  assign bus24.in_b      = in_b;
  assign bus24.in_last   = in_last;
  assign bus24.cfg_retro = cfg_retro;
  assign bus24.prev      = prev;
  assign bus24.out_ready = out_ready;

  assign bus16.in_valid  = in_valid;
  assign bus16.in_a      = in_a;
  assign bus16.in_b      = in_b;
  assign bus16.in_last   = in_last;
  assign bus16.cfg_retro = cfg_retro;
  assign bus16.prev      = prev[15:0];
  assign bus16.out_ready = out_ready;

  mac_stream_unit #(.DATA_W(8), .ACC_W(24), .CNT_W(8)) dut24 (
    .clk(clk), .rst(rst), .bus_if(bus24.slave)
  );
  mac_stream_unit #(.DATA_W(8), .ACC_W(16), .CNT_W(2)) dut16 (
    .clk(clk), .rst(rst), .bus_if(bus16.slave)
  );

  typedef struct {
    int unsigned data;
    int unsigned count;
    bit          ovf;
  } exp_t;

  exp_t q24[$];
  exp_t q16[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Hand-computed result for both lanes; the 16-bit lane's count saturates at 3.
  task automatic expect_result(input int unsigned d24, input int unsigned d16,
                               input int unsigned cnt, input bit o24, input bit o16);
    exp_t e;
    e.data = d24; e.count = cnt; e.ovf = o24;
    q24.push_back(e);
    e.data = d16; e.count = (cnt > 3) ? 3 : cnt; e.ovf = o16;
    q16.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the pair was accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input bit last,
                      input bit retro, input logic [23:0] p);
    bit done = 0;
    bit r;
    in_a = a; in_b = b; in_last = last; cfg_retro = retro; prev = p;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      r = bus24.in_ready;
      @(posedge clk);
      if (r) done = 1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL send_timeout: pair %0d*%0d not accepted, got 0 expected 1", a, b);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: one per lane, pop on every consumed result.
  always @(negedge clk) begin
    if (bus24.out_valid && bus24.out_ready) begin
      exp_t e;
      total++;
      if (q24.size() == 0) begin
        bad++;
        $display("FAIL lane24_unexpected: got data %0d expected no result", bus24.out_data);
      end else begin
        e = q24.pop_front();
        if (bus24.out_data != e.data || bus24.out_count != e.count || bus24.out_ovf != e.ovf) begin
          bad++;
          $display("FAIL lane24_result: got data=%0d cnt=%0d ovf=%0d expected data=%0d cnt=%0d ovf=%0d",
                   bus24.out_data, bus24.out_count, bus24.out_ovf, e.data, e.count, e.ovf);
        end else begin
          $display("lane24 result data=%0d cnt=%0d ovf=%0d ok", e.data, e.count, e.ovf);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus16.out_valid && bus16.out_ready) begin
      exp_t e;
      total++;
      if (q16.size() == 0) begin
        bad++;
        $display("FAIL lane16_unexpected: got data %0d expected no result", bus16.out_data);
      end else begin
        e = q16.pop_front();
        if (bus16.out_data != e.data || bus16.out_count != e.count || bus16.out_ovf != e.ovf) begin
          bad++;
          $display("FAIL lane16_result: got data=%0d cnt=%0d ovf=%0d expected data=%0d cnt=%0d ovf=%0d",
                   bus16.out_data, bus16.out_count, bus16.out_ovf, e.data, e.count, e.ovf);
        end else begin
          $display("lane16 result data=%0d cnt=%0d ovf=%0d ok", e.data, e.count, e.ovf);
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid24"}, bus24.out_valid, 0);
    check({tag, "_data24"},  bus24.out_data, 0);
    check({tag, "_count24"}, bus24.out_count, 0);
    check({tag, "_ovf24"},   bus24.out_ovf, 0);
    check({tag, "_valid16"}, bus16.out_valid, 0);
    check({tag, "_data16"},  bus16.out_data, 0);
  endtask

  initial begin
    // Reset state
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", bus24.in_ready, 1);

    // Vector (3,4),(5,6),(7,8 last): 98, count 3, plus latency
    expect_result(98, 98, 3, 0, 0);
    send(3, 4, 0, 0, 0);
    send(5, 6, 0, 0, 0);
    send(7, 8, 1, 0, 0);
    check("latency_t", bus24.out_valid, 0);
    @(posedge clk); #1;
    check("latency_t1", bus24.out_valid, 1);
    idle(3);

    // Single term with retro seed: 1000 + 100
    expect_result(1100, 1100, 1, 0, 0);
    send(10, 10, 1, 1, 1000);
    idle(3);

    // Retro on a non-first term is ignored; in_last without in_valid is ignored
    expect_result(5, 5, 2, 0, 0);
    send(1, 1, 0, 0, 0);
    in_last = 1'b1;
    idle(2);
    in_last = 1'b0;
    send(2, 2, 1, 1, 500);
    idle(3);

    // Back-to-back single-term vectors
    expect_result(4, 4, 1, 0, 0);
    expect_result(9, 9, 1, 0, 0);
    send(2, 2, 1, 0, 0);
    send(3, 3, 1, 0, 0);
    check("b2b_first_valid", bus24.out_valid, 1);
    @(posedge clk); #1;
    check("b2b_second_valid", bus24.out_valid, 1);
    check("b2b_second_data", bus24.out_data, 9);
    @(posedge clk); #1;
    check("b2b_drained", bus24.out_valid, 0);
    idle(2);

    // Backpressure: result 2 held while a 5-term vector is offered
    expect_result(2, 2, 1, 0, 0);
    expect_result(55, 55, 5, 0, 0);
    out_ready = 1'b0;
    send(1, 2, 1, 0, 0);
    send(1, 1, 0, 0, 0);
    in_a = 2; in_b = 2; in_last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", bus24.in_ready, 0);
      check("bp_data_frozen", bus24.out_data, 2);
      check("bp_valid_held", bus24.out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2, 2, 0, 0, 0);
    send(3, 3, 0, 0, 0);
    send(4, 4, 0, 0, 0);
    send(5, 5, 1, 0, 0);
    idle(4);

    // Overflow: 2*65025 = 130050 fits 24 bits, exceeds 16 bits
`ifdef MAC_SATURATE_EN
    expect_result(130050, 65535, 2, 0, 1);
`else
    expect_result(130050, 64514, 2, 0, 1);
`endif
    send(255, 255, 0, 0, 0);
    send(255, 255, 1, 0, 0);
    idle(4);

    // Reset mid-vector, then a single term restarts cleanly
    send(9, 9, 0, 0, 0);
    send(9, 9, 0, 0, 0);
    rst = 1'b0;
    #2;
    check_zero_outputs("midreset");
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    expect_result(1, 1, 1, 0, 0);
    send(1, 1, 1, 0, 0);
    idle(5);

    check("queue24_empty", q24.size(), 0);
    check("queue16_empty", q16.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
